// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - shared risc16 decode definitions
// Opcodes, field positions and register-usage decode shared by reg_file, ALU and decode_issue.
package decode_issue_pkg;

   localparam int NREGS = 8;
   localparam int SEL_W = 3;
   localparam int IMM_W = 8;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 9;
   localparam int FLAG_BIT = 8;
   localparam int RA_MSB   = 7;
   localparam int RA_LSB   = 5;
   localparam int RB_MSB   = 4;
   localparam int RB_LSB   = 2;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_OR     = 4'h2;
   localparam logic [3:0] OP_XOR    = 4'h3;
   localparam logic [3:0] OP_AND    = 4'h4;
   localparam logic [3:0] OP_NOT    = 4'h5;
   localparam logic [3:0] OP_LOAD   = 4'h8;
   localparam logic [3:0] OP_CMP    = 4'h9;
   localparam logic [3:0] OP_SHL    = 4'hA;
   localparam logic [3:0] OP_SHR    = 4'hB;
   localparam logic [3:0] OP_JUMP   = 4'hC;
   localparam logic [3:0] OP_JUMPEQ = 4'hD;
   localparam logic [3:0] OP_MEM    = 4'hE;

   typedef struct packed {
      logic rd_a;
      logic rd_b;
      logic wr_d;
   } reg_use_t;

   // Opcodes not listed (0110, 0111, 1111) are NOPs: no reads, no write.
   function automatic reg_use_t reg_use(input logic [3:0] op, input logic flag);
      reg_use_t u;
      u = '0;
      case (op)
         OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND,
         OP_CMP, OP_SHL, OP_SHR: begin u.rd_a = 1'b1; u.rd_b = 1'b1; u.wr_d = 1'b1; end
         OP_NOT:    begin u.rd_a = 1'b1; u.wr_d = 1'b1; end
         OP_LOAD:   u.wr_d = 1'b1;
         OP_JUMP:   u.rd_a = 1'b1;
         OP_JUMPEQ: begin u.rd_a = 1'b1; u.rd_b = 1'b1; end
         OP_MEM:    begin u.rd_a = 1'b1; u.rd_b = flag; u.wr_d = ~flag; end
         default:   u = '0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/decode_issue_scoreboard8.sv
// rtl/decode_issue_scoreboard8.sv - pending-write scoreboard for decode_issue
// One bit per register; set on issue, cleared by writeback or flush of the held writer.
module scoreboard8
   import decode_issue_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             set_i,
   input  logic [SEL_W-1:0] set_sel_i,
   input  logic             clr_i,
   input  logic [SEL_W-1:0] clr_sel_i,
   input  logic             fclr_i,
   input  logic [SEL_W-1:0] fclr_sel_i,
   input  logic [SEL_W-1:0] rd_a_sel_i,
   input  logic [SEL_W-1:0] rd_b_sel_i,
   input  logic [SEL_W-1:0] rd_d_sel_i,
   output logic             busy_a_o,
   output logic             busy_b_o,
   output logic             busy_d_o,
   output logic             err_o
);

   logic [NREGS-1:0] pend_q, pend_d;
   logic             err_q, err_d;

   // Set is applied last so it wins over a same-cycle clear of the same bit.
   always_comb begin
      pend_d = pend_q;
      if (clr_i)  pend_d[clr_sel_i]  = 1'b0;
      if (fclr_i) pend_d[fclr_sel_i] = 1'b0;
      if (set_i)  pend_d[set_sel_i]  = 1'b1;
      err_d = err_q | (clr_i & ~pend_q[clr_sel_i]);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign busy_a_o = pend_q[rd_a_sel_i];
   assign busy_b_o = pend_q[rd_b_sel_i];
   assign busy_d_o = pend_q[rd_d_sel_i];
   assign err_o    = err_q;

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - risc16 decode/issue stage with scoreboard stall
// Single output register feeding reg_file; stalls on any pending source or destination.
module decode_issue
   import decode_issue_pkg::*;
(
   input  logic        I_CLK,
   input  logic        I_RST_N,
   input  logic        I_INSTR_VALID,
   input  logic [15:0] I_INSTR,
   output logic        O_INSTR_READY,
   input  logic        I_READY,
   input  logic        I_WB_VALID,
   input  logic [2:0]  I_WB_SELD,
   input  logic        I_FLUSH,
   output logic        O_VALID,
   output logic        O_EN,
   output logic [2:0]  O_SELA,
   output logic [2:0]  O_SELB,
   output logic [2:0]  O_SELD,
   output logic        O_REGWE,
   output logic [3:0]  O_ALUOP,
   output logic        O_FLAG,
   output logic [15:0] O_IMM,
   output logic        O_SB_ERR
);

   logic [3:0]       dec_op;
   logic [SEL_W-1:0] dec_ra, dec_rb, dec_rd;
   logic             dec_flag;
   reg_use_t         dec_use;
   logic             busy_a, busy_b, busy_d, hazard, ready, accept;

   logic             valid_q, valid_d, regwe_q, regwe_d, flag_q, flag_d;
   logic [SEL_W-1:0] sela_q, sela_d, selb_q, selb_d, seld_q, seld_d;
   logic [3:0]       aluop_q, aluop_d;
   logic [15:0]      imm_q, imm_d;

   assign dec_op   = I_INSTR[OPC_MSB:OPC_LSB];
   assign dec_rd   = I_INSTR[RD_MSB:RD_LSB];
   assign dec_flag = I_INSTR[FLAG_BIT];
   assign dec_ra   = I_INSTR[RA_MSB:RA_LSB];
   assign dec_rb   = I_INSTR[RB_MSB:RB_LSB];
   assign dec_use  = reg_use(dec_op, dec_flag);

   assign hazard = (dec_use.rd_a & busy_a) | (dec_use.rd_b & busy_b) | (dec_use.wr_d & busy_d);
   assign ready  = ~I_FLUSH & ~hazard & (~valid_q | I_READY);
   assign accept = I_INSTR_VALID & ready;

   scoreboard8 u_sb (
      .clk_i      (I_CLK),
      .rst_n_i    (I_RST_N),
      .set_i      (accept & dec_use.wr_d),
      .set_sel_i  (dec_rd),
      .clr_i      (I_WB_VALID),
      .clr_sel_i  (I_WB_SELD),
      .fclr_i     (I_FLUSH & valid_q & regwe_q),
      .fclr_sel_i (seld_q),
      .rd_a_sel_i (dec_ra),
      .rd_b_sel_i (dec_rb),
      .rd_d_sel_i (dec_rd),
      .busy_a_o   (busy_a),
      .busy_b_o   (busy_b),
      .busy_d_o   (busy_d),
      .err_o      (O_SB_ERR)
   );

   // Fields hold their last values after a drain or flush; only accept reloads them.
   always_comb begin
      valid_d = valid_q;
      sela_d  = sela_q;
      selb_d  = selb_q;
      seld_d  = seld_q;
      regwe_d = regwe_q;
      aluop_d = aluop_q;
      flag_d  = flag_q;
      imm_d   = imm_q;
      if (I_FLUSH) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         sela_d  = dec_ra;
         selb_d  = dec_rb;
         seld_d  = dec_rd;
         regwe_d = dec_use.wr_d;
         aluop_d = dec_op;
         flag_d  = dec_flag;
         imm_d   = {{(16-IMM_W){1'b0}}, I_INSTR[IMM_W-1:0]};
      end else if (valid_q && I_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         valid_q <= 1'b0;
         sela_q  <= '0;
         selb_q  <= '0;
         seld_q  <= '0;
         regwe_q <= 1'b0;
         aluop_q <= '0;
         flag_q  <= 1'b0;
         imm_q   <= '0;
      end else begin
         valid_q <= valid_d;
         sela_q  <= sela_d;
         selb_q  <= selb_d;
         seld_q  <= seld_d;
         regwe_q <= regwe_d;
         aluop_q <= aluop_d;
         flag_q  <= flag_d;
         imm_q   <= imm_d;
      end
   end

   assign O_INSTR_READY = ready;
   assign O_VALID       = valid_q;
   assign O_EN          = valid_q;
   assign O_SELA        = sela_q;
   assign O_SELB        = selb_q;
   assign O_SELD        = seld_q;
   assign O_REGWE       = regwe_q;
   assign O_ALUOP       = aluop_q;
   assign O_FLAG        = flag_q;
   assign O_IMM         = imm_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - self-checking bench for decode_issue
module tb_decode_issue;

   logic        I_CLK = 1'b0;
   logic        I_RST_N = 1'b0;
   logic        I_INSTR_VALID = 1'b0;
   logic [15:0] I_INSTR = 16'h0;
   logic        I_READY = 1'b1;
   logic        I_WB_VALID = 1'b0;
   logic [2:0]  I_WB_SELD = 3'd0;
   logic        I_FLUSH = 1'b0;
   logic        O_INSTR_READY, O_VALID, O_EN, O_REGWE, O_FLAG, O_SB_ERR;
   logic [2:0]  O_SELA, O_SELB, O_SELD;
   logic [3:0]  O_ALUOP;
   logic [15:0] O_IMM;

   int checks = 0;
   int errors = 0;

   decode_issue dut (
      .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_INSTR_VALID(I_INSTR_VALID), .I_INSTR(I_INSTR),
      .O_INSTR_READY(O_INSTR_READY), .I_READY(I_READY), .I_WB_VALID(I_WB_VALID),
      .I_WB_SELD(I_WB_SELD), .I_FLUSH(I_FLUSH), .O_VALID(O_VALID), .O_EN(O_EN),
      .O_SELA(O_SELA), .O_SELB(O_SELB), .O_SELD(O_SELD), .O_REGWE(O_REGWE),
      .O_ALUOP(O_ALUOP), .O_FLAG(O_FLAG), .O_IMM(O_IMM), .O_SB_ERR(O_SB_ERR)
   );

   always #5 I_CLK = ~I_CLK;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {reads rA, reads rB, writes rD} straight from the opcode usage table.
   function automatic logic [2:0] uses(input logic [15:0] w);
      case (w[15:12])
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB: return 3'b111;
         4'h5: return 3'b101;
         4'h8: return 3'b001;
         4'hC: return 3'b100;
         4'hD: return 3'b110;
         4'hE: return w[8] ? 3'b110 : 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   // Behavioural model: pending set, held word, held write-enable, sticky error.
   bit          pend[8];
   logic        m_valid = 1'b0;
   logic [15:0] m_word = 16'h0;
   logic        m_we = 1'b0;
   logic        m_err = 1'b0;

   function automatic logic m_ready();
      logic [2:0] u;
      logic haz;
      u = uses(I_INSTR);
      haz = (u[2] && pend[I_INSTR[7:5]]) || (u[1] && pend[I_INSTR[4:2]]) || (u[0] && pend[I_INSTR[11:9]]);
      return !I_FLUSH && !haz && (!m_valid || I_READY);
   endfunction

   always @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         foreach (pend[i]) pend[i] = 1'b0;
         m_valid = 1'b0; m_word = 16'h0; m_we = 1'b0; m_err = 1'b0;
      end else begin
         logic acc;
         acc = I_INSTR_VALID && m_ready();
         if (I_WB_VALID) begin
            if (!pend[I_WB_SELD]) m_err = 1'b1;
            pend[I_WB_SELD] = 1'b0;
         end
         if (I_FLUSH && m_valid && m_we) pend[m_word[11:9]] = 1'b0;
         if (acc && uses(I_INSTR)[0]) pend[I_INSTR[11:9]] = 1'b1;
         if (I_FLUSH) m_valid = 1'b0;
         else if (acc) m_valid = 1'b1;
         else if (m_valid && I_READY) m_valid = 1'b0;
         if (acc) begin
            m_word = I_INSTR;
            m_we = uses(I_INSTR)[0];
         end
      end
   end

   always @(negedge I_CLK) begin
      if (I_RST_N) begin
         check("valid", {15'd0, O_VALID}, {15'd0, m_valid});
         check("en", {15'd0, O_EN}, {15'd0, m_valid});
         check("instr_ready", {15'd0, O_INSTR_READY}, {15'd0, m_ready()});
         check("sela", {13'd0, O_SELA}, {13'd0, m_word[7:5]});
         check("selb", {13'd0, O_SELB}, {13'd0, m_word[4:2]});
         check("seld", {13'd0, O_SELD}, {13'd0, m_word[11:9]});
         check("regwe", {15'd0, O_REGWE}, {15'd0, m_we});
         check("aluop", {12'd0, O_ALUOP}, {12'd0, m_word[15:12]});
         check("flag", {15'd0, O_FLAG}, {15'd0, m_word[8]});
         check("imm", O_IMM, {8'h00, m_word[7:0]});
         check("sb_err", {15'd0, O_SB_ERR}, {15'd0, m_err});
      end
   end

   task automatic step(input logic v, input logic [15:0] w, input logic r,
                       input logic wb, input logic [2:0] ws, input logic fl);
      @(negedge I_CLK); #1;
      I_INSTR_VALID = v; I_INSTR = w; I_READY = r;
      I_WB_VALID = wb; I_WB_SELD = ws; I_FLUSH = fl;
   endtask

   task automatic post();
      @(posedge I_CLK); #1;
   endtask

   initial begin
      repeat (3) @(negedge I_CLK);
      #1 I_RST_N = 1'b1;
      #1;
      check("rst_valid", {15'd0, O_VALID}, 16'd0);
      check("rst_ready", {15'd0, O_INSTR_READY}, 16'd1);
      check("rst_err", {15'd0, O_SB_ERR}, 16'd0);

      step(1, 16'h0248, 1, 0, 0, 0); post();
      check("add_valid", {15'd0, O_VALID}, 16'd1);
      check("add_seld", {13'd0, O_SELD}, 16'd1);
      check("add_sela", {13'd0, O_SELA}, 16'd2);
      check("add_selb", {13'd0, O_SELB}, 16'd2);
      check("add_regwe", {15'd0, O_REGWE}, 16'd1);
      check("add_aluop", {12'd0, O_ALUOP}, 16'd0);

      step(1, 16'h1828, 1, 0, 0, 0); post();
      check("raw_drain", {15'd0, O_VALID}, 16'd0);
      check("raw_stall", {15'd0, O_INSTR_READY}, 16'd0);
      step(1, 16'h1828, 1, 1, 3'd1, 0); post();
      check("raw_release", {15'd0, O_INSTR_READY}, 16'd1);
      check("raw_not_yet", {15'd0, O_VALID}, 16'd0);
      step(1, 16'h1828, 1, 0, 0, 0); post();
      check("sub_seld", {13'd0, O_SELD}, 16'd4);
      check("sub_aluop", {12'd0, O_ALUOP}, 16'd1);

      step(1, 16'hC0A0, 1, 0, 0, 0); post();
      check("jump_regwe", {15'd0, O_REGWE}, 16'd0);
      check("jump_sela", {13'd0, O_SELA}, 16'd5);
      step(1, 16'hE9A4, 1, 0, 0, 0); post();
      check("store_valid", {15'd0, O_VALID}, 16'd1);
      check("store_regwe", {15'd0, O_REGWE}, 16'd0);
      check("store_aluop", {12'd0, O_ALUOP}, 16'hE);
      step(0, 16'h0000, 1, 1, 3'd4, 0); post();
      check("wb4_err", {15'd0, O_SB_ERR}, 16'd0);

      step(1, 16'h845A, 1, 0, 0, 0); post();
      check("load_imm", O_IMM, 16'h005A);
      step(1, 16'h0000, 0, 0, 0, 0); post();
      check("bp_valid", {15'd0, O_VALID}, 16'd1);
      check("bp_ready", {15'd0, O_INSTR_READY}, 16'd0);
      step(1, 16'h0000, 0, 0, 0, 0); post();
      check("bp_imm", O_IMM, 16'h005A);
      step(1, 16'h0000, 1, 0, 0, 0); post();
      check("awd_valid", {15'd0, O_VALID}, 16'd1);
      check("awd_imm", O_IMM, 16'h0000);
      step(0, 16'h0000, 1, 1, 3'd2, 0);
      step(0, 16'h0000, 1, 1, 3'd0, 0); post();
      check("wb_err", {15'd0, O_SB_ERR}, 16'd0);

      step(1, 16'h8C00, 0, 0, 0, 0); post();
      check("ld6_seld", {13'd0, O_SELD}, 16'd6);
      step(1, 16'h0248, 0, 0, 0, 1); post();
      check("flush_valid", {15'd0, O_VALID}, 16'd0);
      check("flush_noacc", {13'd0, O_SELA}, 16'd0);
      step(1, 16'h02C0, 1, 0, 0, 0); post();
      check("r6_cleared", {15'd0, O_VALID}, 16'd1);
      check("r6_sela", {13'd0, O_SELA}, 16'd6);
      step(0, 16'h0000, 1, 1, 3'd1, 0);

      step(0, 16'h0000, 1, 1, 3'd7, 0); post();
      check("spur_err", {15'd0, O_SB_ERR}, 16'd1);
      step(0, 16'h0000, 1, 0, 0, 0); post();
      check("spur_sticky", {15'd0, O_SB_ERR}, 16'd1);

      step(1, 16'h0248, 0, 0, 0, 0); post();
      check("pre_rst_valid", {15'd0, O_VALID}, 16'd1);
      #2 I_RST_N = 1'b0;
      #1;
      check("arst_valid", {15'd0, O_VALID}, 16'd0);
      check("arst_en", {15'd0, O_EN}, 16'd0);
      check("arst_sel", {7'd0, O_SELA, O_SELB, O_SELD}, 16'd0);
      check("arst_imm", O_IMM, 16'd0);
      check("arst_regwe", {15'd0, O_REGWE}, 16'd0);
      check("arst_err", {15'd0, O_SB_ERR}, 16'd0);
      @(negedge I_CLK); #1;
      I_INSTR_VALID = 1'b0; I_READY = 1'b1; I_WB_VALID = 1'b0; I_FLUSH = 1'b0;
      I_RST_N = 1'b1;
      #1 check("arst_ready", {15'd0, O_INSTR_READY}, 16'd1);
      repeat (2) @(negedge I_CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
